// File: rtl/fvh_pattern_source.sv
// Synthetic interlaced video source: emits the {fvh, dv, data} stream of the 656 decoder
// with a horizontal ramp, a single bright "laser" column, or a solid level.
module fvh_pattern_source #(
  parameter int H_ACTIVE = 720,
  parameter int H_BLANK  = 138,
  parameter int V_ACTIVE = 243,
  parameter int V_BLANK  = 19,
  parameter int DV_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [9:0] laser_col,
  input  logic [7:0] level,
  output logic [2:0] fvh_out,
  output logic       dv_out,
  output logic [7:0] dout,
  output logic       field_start
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int TW      = (DV_DIV > 1) ? $clog2(DV_DIV) : 1;

  localparam logic [7:0] BLACK  = 8'h10;
  localparam logic [7:0] BRIGHT = 8'hFF;
  localparam logic [7:0] DIM    = 8'h20;

  // Handshake: dv_out is a one-clk strobe; fvh_out/dout are valid while dv_out=1 and
  // hold their value until the next strobe. There is no backpressure.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          field;

  logic [1:0]    mode_q;
  logic [9:0]    laser_col_q;
  logic [7:0]    level_q;

  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          field_end;
  logic          load_cfg;
  logic          h_blank;
  logic          v_blank;
  logic [15:0]   hcnt_w;
  logic [7:0]    pixel;

  always_comb begin
    tick      = (state == RUN) && (tick_cnt == TW'(DV_DIV - 1));
    h_last    = (hcnt == HW'(H_TOTAL - 1));
    v_last    = (vcnt == VW'(V_TOTAL - 1));
    field_end = tick && h_last && v_last;
    // Config is captured on IDLE->RUN and again at every field boundary,
    // so a field is always drawn with one consistent pattern.
    load_cfg  = ((state == IDLE) && enable) || field_end;
    h_blank   = (hcnt >= HW'(H_ACTIVE));
    v_blank   = (vcnt >= VW'(V_ACTIVE));
    hcnt_w    = 16'(hcnt);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: stopping is only allowed once the current field is complete
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (field_end && !enable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample-rate divider and raster counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      field    <= 1'b0;
    end else begin
      if (state == RUN) begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end else begin
        tick_cnt <= '0;
      end
      if (tick) begin
        if (h_last) begin
          hcnt <= '0;
          if (v_last) begin
            vcnt  <= '0;
            field <= ~field;
          end else begin
            vcnt <= vcnt + VW'(1);
          end
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  // Shadowed pattern configuration
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q      <= 2'd0;
      laser_col_q <= 10'd0;
      level_q     <= 8'd0;
    end else if (load_cfg) begin
      mode_q      <= mode;
      laser_col_q <= laser_col;
      level_q     <= level;
    end
  end

  // Pattern generator for the sample at (hcnt, vcnt)
  always_comb begin
    pixel = BLACK;
    if (!h_blank && !v_blank) begin
      case (mode_q)
        2'd0:    pixel = hcnt_w[7:0];
        2'd1:    pixel = (hcnt_w == 16'(laser_col_q)) ? BRIGHT : DIM;
        default: pixel = level_q;
      endcase
    end
  end

  // Registered outputs: one clk from tick to strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fvh_out     <= 3'b011;
      dv_out      <= 1'b0;
      dout        <= BLACK;
      field_start <= 1'b0;
    end else if (state == RUN) begin
      dv_out      <= tick;
      field_start <= tick && (hcnt == '0) && (vcnt == '0);
      if (tick) begin
        fvh_out <= {field, v_blank, h_blank};
        dout    <= pixel;
      end
    end else begin
      fvh_out     <= {field, 2'b11};
      dv_out      <= 1'b0;
      dout        <= BLACK;
      field_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fvh_pattern_source.sv
// Bench for fvh_pattern_source: sample-index reference model checked every clk,
// directed literal checks of raster timing and patterns, then randomized traffic.
module tb_fvh_pattern_source;

  localparam int HA  = 8;
  localparam int HB  = 4;
  localparam int VA  = 4;
  localparam int VB  = 2;
  localparam int DIV = 2;
  localparam int HT  = HA + HB;
  localparam int FIELD_SAMPLES = HT * (VA + VB);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic [9:0] laser_col;
  logic [7:0] level;
  logic [2:0] fvh_out;
  logic       dv_out;
  logic [7:0] dout;
  logic       field_start;

  int n_vec = 0;
  int n_err = 0;

  fvh_pattern_source #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .DV_DIV(DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .laser_col(laser_col), .level(level), .fvh_out(fvh_out), .dv_out(dv_out),
    .dout(dout), .field_start(field_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: linear sample index within the field ----------------
  logic       m_valid = 1'b0;
  logic       m_run;
  int         m_ph;
  int         m_s;
  logic       m_f;
  logic [1:0] m_mode;
  logic [9:0] m_lc;
  logic [7:0] m_lv;
  logic [2:0] e_fvh;
  logic       e_dv;
  logic [7:0] e_dout;
  logic       e_fs;

  function automatic logic [7:0] model_pix(input int s, input logic [1:0] m,
                                           input logic [9:0] lc, input logic [7:0] lv);
    int col = s % HT;
    int line = s / HT;
    if (col >= HA || line >= VA) return 8'h10;
    if (m == 2'd0) return 8'(col % 256);
    if (m == 2'd1) return (col == int'(lc)) ? 8'hFF : 8'h20;
    return lv;
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!reset_n) begin
      m_run = 1'b0; m_ph = 0; m_s = 0; m_f = 1'b0;
      e_fvh = 3'b011; e_dv = 1'b0; e_dout = 8'h10; e_fs = 1'b0;
    end else if (!m_run) begin
      e_fvh = {m_f, 2'b11}; e_dv = 1'b0; e_dout = 8'h10; e_fs = 1'b0;
      if (enable) begin
        m_run = 1'b1; m_ph = 0;
        m_mode = mode; m_lc = laser_col; m_lv = level;
      end
    end else begin
      e_dv = 1'b0; e_fs = 1'b0;
      if (m_ph == DIV - 1) begin
        m_ph   = 0;
        e_dv   = 1'b1;
        e_fs   = (m_s == 0);
        e_fvh  = {m_f, (m_s / HT) >= VA, (m_s % HT) >= HA};
        e_dout = model_pix(m_s, m_mode, m_lc, m_lv);
        m_s++;
        if (m_s == FIELD_SAMPLES) begin
          m_s = 0; m_f = ~m_f;
          m_mode = mode; m_lc = laser_col; m_lv = level;
          if (!enable) m_run = 1'b0;
        end
      end else begin
        m_ph++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_dv", 32'(dv_out), 32'(e_dv));
      check("model_fvh", 32'(fvh_out), 32'(e_fvh));
      check("model_dout", 32'(dout), 32'(e_dout));
      check("model_fs", 32'(field_start), 32'(e_fs));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_dv(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (dv_out) ok = 1'b1;
    end
  endtask

  task automatic wait_fs(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (dv_out && field_start) ok = 1'b1;
    end
  endtask

  logic [7:0] line_exp [12];
  logic [7:0] laser_exp [8];

  initial begin
    logic ok;
    int   cnt;
    logic prev_f;

    line_exp  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h10, 8'h10, 8'h10, 8'h10};
    laser_exp = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'hFF, 8'h20, 8'h20};

    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; laser_col = 10'd0; level = 8'h40;
    repeat (3) @(negedge clk);
    check("rst_fvh", 32'(fvh_out), 32'h3);
    check("rst_dv", 32'(dv_out), 32'h0);
    check("rst_dout", 32'(dout), 32'h10);
    check("rst_fs", 32'(field_start), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Ramp: first strobe two clks after enable is taken
    enable = 1'b1; mode = 2'd0;
    @(negedge clk); check("lat_dv0", 32'(dv_out), 32'h0);
    @(negedge clk); check("lat_dv1", 32'(dv_out), 32'h0);
    @(negedge clk); check("lat_dv2", 32'(dv_out), 32'h1);
    check("first_fs", 32'(field_start), 32'h1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        wait_dv(4, ok);
        if (!ok) check("line0_timeout", 32'h0, 32'h1);
        check("line0_fs", 32'(field_start), 32'h0);
      end
      check("line0_dout", 32'(dout), 32'(line_exp[k]));
      check("line0_fvh", 32'(fvh_out), (k < 8) ? 32'h0 : 32'h1);
    end

    // Count strobes until the next field_start: expect strobe #73 with f=1
    cnt = 12; prev_f = 1'b0; ok = 1'b1;
    while (ok && !field_start) begin
      prev_f = fvh_out[2];
      wait_dv(4, ok);
      if (ok) cnt++;
    end
    if (!ok) check("field_timeout", 32'h0, 32'h1);
    check("field_fs_index", 32'(cnt), 32'd73);
    check("field_prev_f", 32'(prev_f), 32'h0);
    check("field_new_f", 32'(fvh_out[2]), 32'h1);

    // Laser column 5, then out-of-range column 9
    mode = 2'd1; laser_col = 10'd5;
    wait_fs(400, ok);
    if (!ok) check("laser_timeout", 32'h0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) wait_dv(4, ok);
      check("laser5_dout", 32'(dout), 32'(laser_exp[k]));
    end
    laser_col = 10'd9;
    wait_fs(400, ok);
    if (!ok) check("laser9_timeout", 32'h0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) wait_dv(4, ok);
      check("laser9_dout", 32'(dout), 32'h20);
    end

    // Solid level change mid-field takes effect only at the next field
    mode = 2'd2; level = 8'h40;
    wait_fs(400, ok);
    if (!ok) check("level_timeout", 32'h0, 32'h1);
    check("level40_first", 32'(dout), 32'h40);
    wait_dv(4, ok);
    level = 8'h80;
    wait_dv(4, ok);
    check("level40_hold", 32'(dout), 32'h40);
    wait_fs(400, ok);
    if (!ok) check("level80_timeout", 32'h0, 32'h1);
    check("level80_next", 32'(dout), 32'h80);

    // Enable drop mid-field: field completes, then idle
    repeat (20) @(negedge clk);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400 && cnt < 6; i++) begin
      @(negedge clk);
      cnt = dv_out ? 0 : cnt + 1;
    end
    check("stop_idle_reached", 32'(cnt), 32'd6);
    check("stop_fvh_blank", 32'(fvh_out[1:0]), 32'h3);
    check("stop_dout", 32'(dout), 32'h10);
    enable = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("restart_dv", 32'(dv_out), 32'h1);
    check("restart_fs", 32'(field_start), 32'h1);

    // One-clk reset mid-line with enable held high
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_fvh", 32'(fvh_out), 32'h3);
    check("midrst_dv", 32'(dv_out), 32'h0);
    check("midrst_dout", 32'(dout), 32'h10);
    check("midrst_fs", 32'(field_start), 32'h0);
    reset_n = 1'b1;
    wait_dv(6, ok);
    check("midrst_restart_fs", 32'(field_start & ok), 32'h1);
    check("midrst_restart_fvh", 32'(fvh_out), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) laser_col = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) level = 8'($urandom_range(0, 255));
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
